// File: rtl/exception_controller_if.sv
// Handshake bundle between the exception detector, the controller and the
// flush / PC-select consumers.
interface exception_controller_if #(
    parameter int PC_WIDTH    = 6,
    parameter int COUNT_WIDTH = 4
);
    logic [2:0]             exc_cause;
    logic [PC_WIDTH-1:0]    exc_pc;
    logic                   exc_en;
    logic                   eret;
    logic                   flush_if;
    logic                   flush_id;
    logic                   flush_ex;
    logic                   pc_sel;
    logic [PC_WIDTH-1:0]    pc_target;
    logic [PC_WIDTH-1:0]    epc;
    logic [2:0]             cause_reg;
    logic                   in_handler;
    logic                   exc_clear;
    logic [COUNT_WIDTH-1:0] exc_count;
    logic                   overrun;

    modport master (
        output exc_cause, exc_pc, exc_en, eret,
        input  flush_if, flush_id, flush_ex, pc_sel, pc_target,
        input  epc, cause_reg, in_handler, exc_clear, exc_count, overrun
    );

    modport slave (
        input  exc_cause, exc_pc, exc_en, eret,
        output flush_if, flush_id, flush_ex, pc_sel, pc_target,
        output epc, cause_reg, in_handler, exc_clear, exc_count, overrun
    );
endinterface

// File: rtl/exception_controller.sv
// Exception sequencer: edge-detects a detector cause, flushes, redirects to
// the handler vector and returns past the faulting PC on eret.
module exception_controller #(
    parameter int                  PC_WIDTH     = 6,
    parameter logic [PC_WIDTH-1:0] HANDLER_VEC  = 6'd60,
    parameter int                  FLUSH_CYCLES = 2,
    parameter int                  RET_OFFSET   = 1,
    parameter int                  COUNT_WIDTH  = 4
) (
    input logic                   clk,
    input logic                   rst,
    exception_controller_if.slave exc_if
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_REDIRECT,
        S_HANDLER,
        S_RETURN
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [2:0]             r_cnt;
    logic [2:0]             w_cnt_nxt;
    logic [2:0]             r_prev_cause;
    logic                   w_event;
    logic                   w_take;

    logic                   r_flush_if, w_flush_if;
    logic                   r_flush_id, w_flush_id;
    logic                   r_flush_ex, w_flush_ex;
    logic                   r_pc_sel, w_pc_sel;
    logic [PC_WIDTH-1:0]    r_pc_target, w_pc_target;
    logic [PC_WIDTH-1:0]    r_epc, w_epc;
    logic [2:0]             r_cause, w_cause;
    logic                   r_in_handler, w_in_handler;
    logic                   r_exc_clear, w_exc_clear;
    logic [COUNT_WIDTH-1:0] r_count, w_count;
    logic                   r_overrun, w_overrun;

    always_comb begin
        w_event     = (exc_if.exc_cause != 3'd0) && (r_prev_cause == 3'd0);
        w_take      = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_event && exc_if.exc_en) begin
                    w_take      = 1'b1;
                    w_state_nxt = S_FLUSH;
                    w_cnt_nxt   = 3'(FLUSH_CYCLES);
                end
            end
            S_FLUSH: begin
                if (r_cnt <= 3'd1) begin
                    w_state_nxt = S_REDIRECT;
                    w_cnt_nxt   = 3'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            S_REDIRECT: w_state_nxt = S_HANDLER;
            S_HANDLER: begin
                if (exc_if.eret) w_state_nxt = S_RETURN;
            end
            S_RETURN: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase

        w_epc     = w_take ? exc_if.exc_pc : r_epc;
        w_cause   = w_take ? exc_if.exc_cause : r_cause;
        w_count   = r_count;
        if (w_take && (r_count != '1)) w_count = r_count + 1'b1;
        // Any edge outside IDLE is lost, including during RETURN
        w_overrun = r_overrun | (w_event && (r_state != S_IDLE));

        // Outputs are registered off the next state
        w_flush_if   = 1'b0;
        w_flush_id   = 1'b0;
        w_flush_ex   = 1'b0;
        w_pc_sel     = 1'b0;
        w_pc_target  = '0;
        w_in_handler = 1'b0;
        w_exc_clear  = 1'b0;
        unique case (w_state_nxt)
            S_FLUSH: begin
                w_flush_if = 1'b1;
                w_flush_id = 1'b1;
                w_flush_ex = 1'b1;
            end
            S_REDIRECT: begin
                w_pc_sel    = 1'b1;
                w_pc_target = HANDLER_VEC;
                w_flush_if  = 1'b1;
            end
            S_HANDLER: w_in_handler = 1'b1;
            S_RETURN: begin
                w_pc_sel    = 1'b1;
                w_pc_target = r_epc + PC_WIDTH'(RET_OFFSET);
                w_flush_if  = 1'b1;
                w_exc_clear = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 3'd0;
            r_prev_cause <= 3'd0;
            r_flush_if   <= 1'b0;
            r_flush_id   <= 1'b0;
            r_flush_ex   <= 1'b0;
            r_pc_sel     <= 1'b0;
            r_pc_target  <= '0;
            r_epc        <= '0;
            r_cause      <= 3'd0;
            r_in_handler <= 1'b0;
            r_exc_clear  <= 1'b0;
            r_count      <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_prev_cause <= exc_if.exc_cause;
            r_flush_if   <= w_flush_if;
            r_flush_id   <= w_flush_id;
            r_flush_ex   <= w_flush_ex;
            r_pc_sel     <= w_pc_sel;
            r_pc_target  <= w_pc_target;
            r_epc        <= w_epc;
            r_cause      <= w_cause;
            r_in_handler <= w_in_handler;
            r_exc_clear  <= w_exc_clear;
            r_count      <= w_count;
            r_overrun    <= w_overrun;
        end
    end

    assign exc_if.flush_if   = r_flush_if;
    assign exc_if.flush_id   = r_flush_id;
    assign exc_if.flush_ex   = r_flush_ex;
    assign exc_if.pc_sel     = r_pc_sel;
    assign exc_if.pc_target  = r_pc_target;
    assign exc_if.epc        = r_epc;
    assign exc_if.cause_reg  = r_cause;
    assign exc_if.in_handler = r_in_handler;
    assign exc_if.exc_clear  = r_exc_clear;
    assign exc_if.exc_count  = r_count;
    assign exc_if.overrun    = r_overrun;
endmodule

// File: doc/exception_controller.md
Name: exception_controller

Overview:
- Downstream consumer of the pipeline exception detector's (ExceptionCause, ExceptionPC) pair.
- Turns a newly raised cause into a timed flush of IF/ID/EX, a PC redirect to a fixed handler vector, and holds EPC/Cause state for the handler.
- On handler return (eret), steers the PC back past the faulting instruction and pulses a clear back to the detector.
- Sits between the exception detector, the hazard/flush logic and the PC-select mux.

Parameters:
- PC_WIDTH, 6, width of all PC values.
- HANDLER_VEC, 6'd60, PC of the exception handler entry.
- FLUSH_CYCLES, 2, number of cycles the flush outputs are held (legal range 1..7).
- RET_OFFSET, 1, added to EPC on return (word-addressed PC).
- COUNT_WIDTH, 4, width of the exception counter.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- exc_cause  in  3  cause from detector; 0 = none; 1 opcode, 2 function, 3 register, 4 overflow; 5..7 reserved
- exc_pc  in  PC_WIDTH  faulting PC from detector
- exc_en  in  1  global exception enable; 0 masks new events
- eret  in  1  return-from-handler strobe (decoded in ID)
- flush_if, flush_id, flush_ex  out  1 each  flush the corresponding pipeline register
- pc_sel  out  1  1 = PC mux takes pc_target
- pc_target  out  PC_WIDTH  redirect PC
- epc  out  PC_WIDTH  latched faulting PC
- cause_reg  out  3  latched cause
- in_handler  out  1  high while the handler executes
- exc_clear  out  1  one-cycle pulse to clear the detector's cause
- exc_count  out  COUNT_WIDTH  exceptions taken, saturating
- overrun  out  1  sticky: an event arrived while not IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; prev_cause 0; flush counter 0. Reset applies in any state, mid-flush or mid-handler, and aborts the operation with no exc_clear.
- prev_cause register: updated with exc_cause every cycle.
- Event: exc_cause != 0 and prev_cause == 0, sampled at the rising edge. This is edge detection because the detector holds the cause level.
- States: IDLE, FLUSH, REDIRECT, HANDLER, RETURN.
- IDLE:
  - Event with exc_en=1: latch epc <= exc_pc and cause_reg <= exc_cause (reserved codes are stored as-is). exc_count +1, saturating at all-ones. Go to FLUSH with counter = FLUSH_CYCLES.
  - Event with exc_en=0: dropped permanently. No state change; the edge is still consumed.
- FLUSH: flush_if, flush_id and flush_ex are all 1. Counter decrements each cycle. Exactly FLUSH_CYCLES cycles are spent here, then the block goes to REDIRECT.
- REDIRECT: exactly 1 cycle. pc_sel=1, pc_target=HANDLER_VEC, flush_if=1. Next state is HANDLER.
- HANDLER: in_handler=1, remains here until eret=1. eret in HANDLER moves to RETURN.
- RETURN: exactly 1 cycle.
  - pc_sel=1, pc_target = (epc + RET_OFFSET) mod 2^PC_WIDTH; wraps, no carry out.
  - flush_if=1, exc_clear=1.
  - Next state IDLE. epc and cause_reg are held until the next taken event.
- Outputs: all registered, a function of the current state only. Total latency from the event edge to the handler PC is FLUSH_CYCLES+1 cycles.
- Event in any non-IDLE state: not taken; overrun <= 1. overrun is sticky and cleared only by rst.
- eret outside HANDLER: ignored.
- Event and eret in the same cycle while in HANDLER: eret wins and overrun is set.
- Cause 0 to nonzero during RETURN: counts as overrun; it is not queued.
- Outputs not asserted by the current state are 0.

Test Plan:
- rst=1 for 2 cycles, then exc_cause=4, exc_pc=6'd13, exc_en=1 -> after the edge:
  - flush_* high exactly 2 cycles.
  - Then pc_sel=1, pc_target=60 for 1 cycle.
  - Then in_handler=1; epc=13, cause_reg=4, exc_count=1.
- In HANDLER, pulse eret -> next cycle pc_sel=1, pc_target=14, exc_clear=1, flush_if=1; following cycle IDLE with all strobes 0.
- exc_pc=6'd63, cause 1, then eret -> pc_target=0 (wrap).
- exc_en=0 with cause rising 0 to 2, then exc_en=1 while cause is held at 2 -> no flush ever; exc_count unchanged.
- During FLUSH, detector cause drops to 0 then rises to 3 -> overrun=1; sequence completes with cause_reg unchanged.
- 17 taken exceptions (each returned with eret, cause toggled to 0 between them) -> exc_count=15. rst asserted mid-FLUSH -> next cycle all outputs 0, overrun=0.
